// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC DDR pattern transmitter and its receive-side checker:
// FSM states, payload pattern codes, sync/midscale constants and the PN9 stepping function.
package adc_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    PAT_FIXED    = 3'd0,
    PAT_RAMP     = 3'd1,
    PAT_CHECKER  = 3'd2,
    PAT_PN9      = 3'd3,
    PAT_MIDSCALE = 3'd4
  } pattern_e;

  localparam logic [7:0] SYNC_A     = 8'hA5;
  localparam logic [7:0] SYNC_B     = 8'h5A;
  localparam logic [7:0] MIDSCALE   = 8'h80;
  localparam logic [7:0] CHECK_EVEN = 8'h55;
  localparam logic [7:0] CHECK_ODD  = 8'hAA;

  // x^9 + x^5 + 1: the oldest bit (output) and the bit four places behind it feed back.
  localparam int PN9_TAP_HI = 8;
  localparam int PN9_TAP_LO = 4;

  typedef struct packed {
    logic [8:0]  state;
    logic [15:0] bits;
  } pn9_adv_t;

  // Advance a PN9 register 16 steps; the first output bit lands in bits[15].
  function automatic pn9_adv_t pn9_advance16(input logic [8:0] seed);
    pn9_adv_t   res;
    logic [8:0] s;
    logic       fb;
    s        = seed;
    res.bits = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      res.bits = {res.bits[14:0], s[PN9_TAP_HI]};
      fb       = s[PN9_TAP_HI] ^ s[PN9_TAP_LO];
      s        = {s[7:0], fb};
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/adc_ddr_pattern_tx_pn9_gen.sv
// PN9 generator: seed load, 16-bit-per-step advance, 16-bit parallel output of the next
// bits to be sent. Shared with the receive-side pattern checker.
module pn9_gen
  import adc_if_pkg::*;
#(
  parameter logic [8:0] SEED = 9'h1FF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] bits
);

  logic [8:0] lfsr_r;
  pn9_adv_t   adv_s;

  // Look-ahead of the next 16 output bits and the register state after them.
  always_comb begin
    adv_s = pn9_advance16(lfsr_r);
  end

  assign bits = adv_s.bits;

  // Register update; load wins over advance so a new burst always restarts the sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= SEED;
    end else if (advance) begin
      lfsr_r <= adv_s.state;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

endmodule

// File: rtl/adc_ddr_pattern_tx.sv
// AD9284-style dual-channel DDR pattern source: registered rise/fall bytes plus DCO enable,
// framed by a start/busy/done handshake with preamble, payload patterns and stop/abort.
module adc_ddr_pattern_tx
  import adc_if_pkg::*;
#(
  parameter int         DATA_WIDTH   = 8,
  parameter int         PREAMBLE_LEN = 4,
  parameter logic [8:0] PN_SEED      = 9'h1FF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] fixed_a,
  input  logic [DATA_WIDTH-1:0] fixed_b,
  input  logic [15:0]           burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  dco_en,
  output logic                  frame,
  output logic [DATA_WIDTH-1:0] data_rise,
  output logic [DATA_WIDTH-1:0] data_fall
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN);

  tx_state_e             state_r;
  logic [2:0]            pattern_r;
  logic [15:0]           burst_len_r;
  logic [DATA_WIDTH-1:0] fixed_a_r;
  logic [DATA_WIDTH-1:0] fixed_b_r;
  logic [3:0]            pre_cnt_r;
  logic [15:0]           word_cnt_r;

  logic                  complete_s;
  logic                  pn_load_s;
  logic                  pn_adv_s;
  logic [15:0]           pn_bits_s;
  logic [DATA_WIDTH-1:0] payload_a_s;
  logic [DATA_WIDTH-1:0] payload_b_s;

  pn9_gen #(
    .SEED (PN_SEED)
  ) u_pn9 (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (pn_load_s),
    .advance (pn_adv_s),
    .bits    (pn_bits_s)
  );

  // word_cnt_r counts words already sent; a zero length never completes on its own.
  assign complete_s = (burst_len_r != 16'h0000) && (word_cnt_r == burst_len_r);

  // PN control: reload on burst acceptance, step once per payload word actually emitted.
  always_comb begin
    pn_load_s = 1'b0;
    pn_adv_s  = 1'b0;
    case (state_r)
      ST_IDLE:     pn_load_s = start;
      ST_PREAMBLE: pn_adv_s  = !stop && (pre_cnt_r == PRE_LAST);
      ST_RUN:      pn_adv_s  = !stop && !complete_s;
      ST_DONE:     pn_adv_s  = 1'b0;
      default:     pn_adv_s  = 1'b0;
    endcase
  end

  // Payload word for index word_cnt_r, registered directly into the output stage.
  always_comb begin
    payload_a_s = fixed_a_r;
    payload_b_s = fixed_b_r;
    case (pattern_r)
      PAT_RAMP: begin
        payload_a_s = DATA_WIDTH'(word_cnt_r[7:0]);
        payload_b_s = DATA_WIDTH'(~word_cnt_r[7:0]);
      end
      PAT_CHECKER: begin
        if (word_cnt_r[0]) begin
          payload_a_s = DATA_WIDTH'(CHECK_ODD);
          payload_b_s = DATA_WIDTH'(CHECK_EVEN);
        end else begin
          payload_a_s = DATA_WIDTH'(CHECK_EVEN);
          payload_b_s = DATA_WIDTH'(CHECK_ODD);
        end
      end
      PAT_PN9: begin
        payload_a_s = DATA_WIDTH'(pn_bits_s[15:8]);
        payload_b_s = DATA_WIDTH'(pn_bits_s[7:0]);
      end
      PAT_MIDSCALE: begin
        payload_a_s = DATA_WIDTH'(MIDSCALE);
        payload_b_s = DATA_WIDTH'(MIDSCALE);
      end
      default: begin
        payload_a_s = fixed_a_r;
        payload_b_s = fixed_b_r;
      end
    endcase
  end

  // Burst FSM; outputs are registered for the state being entered, so they default to idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      pattern_r   <= 3'd0;
      burst_len_r <= 16'h0000;
      fixed_a_r   <= '0;
      fixed_b_r   <= '0;
      pre_cnt_r   <= 4'd0;
      word_cnt_r  <= 16'h0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      dco_en      <= 1'b0;
      frame       <= 1'b0;
      data_rise   <= '0;
      data_fall   <= '0;
    end else begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dco_en    <= 1'b0;
      frame     <= 1'b0;
      data_rise <= '0;
      data_fall <= '0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_PREAMBLE;
            pattern_r   <= pattern_sel;
            burst_len_r <= burst_len;
            fixed_a_r   <= fixed_a;
            fixed_b_r   <= fixed_b;
            pre_cnt_r   <= 4'd1;
            word_cnt_r  <= 16'h0000;
            busy        <= 1'b1;
            dco_en      <= 1'b1;
            data_rise   <= DATA_WIDTH'(SYNC_A);
            data_fall   <= DATA_WIDTH'(SYNC_B);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PREAMBLE: begin
          if (stop) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else if (pre_cnt_r == PRE_LAST) begin
            state_r    <= ST_RUN;
            word_cnt_r <= word_cnt_r + 16'h0001;
            busy       <= 1'b1;
            dco_en     <= 1'b1;
            frame      <= 1'b1;
            data_rise  <= payload_a_s;
            data_fall  <= payload_b_s;
          end else begin
            pre_cnt_r <= pre_cnt_r + 4'd1;
            busy      <= 1'b1;
            dco_en    <= 1'b1;
            data_rise <= DATA_WIDTH'(SYNC_A);
            data_fall <= DATA_WIDTH'(SYNC_B);
          end
        end
        ST_RUN: begin
          // Stop and natural completion both end in a single DONE cycle.
          if (stop || complete_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            word_cnt_r <= word_cnt_r + 16'h0001;
            busy       <= 1'b1;
            dco_en     <= 1'b1;
            data_rise  <= payload_a_s;
            data_fall  <= payload_b_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ddr_pattern_tx.sv
// Scoreboard bench for adc_ddr_pattern_tx: bursts push expected words, a monitor pops and
// compares them every cycle the DUT is busy or signalling done.
module tb_adc_ddr_pattern_tx;

  localparam int DW  = 8;
  localparam int PRE = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic [2:0]    pattern_sel;
  logic [DW-1:0] fixed_a;
  logic [DW-1:0] fixed_b;
  logic [15:0]   burst_len;
  logic          busy;
  logic          done;
  logic          dco_en;
  logic          frame;
  logic [DW-1:0] data_rise;
  logic [DW-1:0] data_fall;

  adc_ddr_pattern_tx #(
    .DATA_WIDTH   (DW),
    .PREAMBLE_LEN (PRE),
    .PN_SEED      (9'h1FF)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .pattern_sel (pattern_sel),
    .fixed_a     (fixed_a),
    .fixed_b     (fixed_b),
    .burst_len   (burst_len),
    .busy        (busy),
    .done        (done),
    .dco_en      (dco_en),
    .frame       (frame),
    .data_rise   (data_rise),
    .data_fall   (data_fall)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] rise;
    logic [7:0] fall;
    logic       frm;
    logic       dn;
    logic       bsy;
    logic       dco;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    pn_bits [0:2047];

  // PN9 output stream from the recurrence o[k] = o[k-9] ^ o[k-5], seed 0x1FF.
  function automatic void build_pn();
    for (int k = 0; k < 2048; k++) begin
      if (k < 9) pn_bits[k] = 1'b1;
      else       pn_bits[k] = pn_bits[k-9] ^ pn_bits[k-5];
    end
  endfunction

  function automatic item_t payload_item(input int pat, input int n,
                                         input logic [7:0] fa, input logic [7:0] fb);
    item_t      it;
    logic [7:0] a;
    logic [7:0] b;
    case (pat)
      1: begin a = 8'(n % 256); b = ~a; end
      2: begin
        if (n % 2 == 0) begin a = 8'h55; b = 8'hAA; end
        else            begin a = 8'hAA; b = 8'h55; end
      end
      3: begin
        for (int k = 0; k < 8; k++) begin
          a[7-k] = pn_bits[16*n + k];
          b[7-k] = pn_bits[16*n + 8 + k];
        end
      end
      4:       begin a = 8'h80; b = 8'h80; end
      default: begin a = fa;    b = fb;    end
    endcase
    it = '{rise: a, fall: b, frm: (n == 0), dn: 1'b0, bsy: 1'b1, dco: 1'b1};
    return it;
  endfunction

  // Monitor: one comparison per cycle, #1 after the active edge.
  always @(posedge clock) begin
    item_t got;
    item_t exp_it;
    #1;
    if (mon_en) begin
      got = '{rise: data_rise, fall: data_fall, frm: frame, dn: done, bsy: busy, dco: dco_en};
      checks++;
      if (exp_q.size() != 0) begin
        exp_it = exp_q.pop_front();
        if (got !== exp_it) begin
          errors++;
          $display("FAIL word t=%0t got r=%h f=%h frame=%b done=%b busy=%b dco=%b required r=%h f=%h frame=%b done=%b busy=%b dco=%b",
                   $time, got.rise, got.fall, got.frm, got.dn, got.bsy, got.dco,
                   exp_it.rise, exp_it.fall, exp_it.frm, exp_it.dn, exp_it.bsy, exp_it.dco);
        end
      end else if (got !== 20'h0) begin
        errors++;
        $display("FAIL idle t=%0t got %h required 00000", $time, got);
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({data_rise, data_fall, frame, done, busy, dco_en} !== 20'h0) begin
      errors++;
      $display("FAIL %s got r=%h f=%h frame=%b done=%b busy=%b dco=%b required all zero",
               name, data_rise, data_fall, frame, done, busy, dco_en);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  // stop_at / mid_start are cycle indices from the first preamble word (-1 = never).
  task automatic run_burst(input int pat, input int len, input logic [7:0] fa,
                           input logic [7:0] fb, input int stop_at, input int mid_start,
                           input bit stop_with_start);
    int    n_items;
    item_t sync_it;
    n_items = (stop_at >= 0) ? stop_at + 1 : PRE + len;
    sync_it = '{rise: 8'hA5, fall: 8'h5A, frm: 1'b0, dn: 1'b0, bsy: 1'b1, dco: 1'b1};
    @(negedge clock);
    for (int i = 0; i < n_items; i++) begin
      if (i < PRE) exp_q.push_back(sync_it);
      else         exp_q.push_back(payload_item(pat, i - PRE, fa, fb));
    end
    exp_q.push_back('{rise: 8'h00, fall: 8'h00, frm: 1'b0, dn: 1'b1, bsy: 1'b0, dco: 1'b0});
    pattern_sel = 3'(pat);
    burst_len   = 16'(len);
    fixed_a     = fa;
    fixed_b     = fb;
    start       = 1'b1;
    stop        = stop_with_start;
    for (int j = 0; j <= n_items; j++) begin
      @(negedge clock);
      start = (j == mid_start);
      stop  = (j == stop_at);
      if (j == 0 || start) begin
        pattern_sel = 3'($urandom_range(0, 7));
        burst_len   = 16'($urandom_range(1, 5));
        fixed_a     = 8'($urandom);
        fixed_b     = 8'($urandom);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    drain();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat;
    int len;
    int stop_at;
    build_pn();
    reset_n     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    pattern_sel = 3'd0;
    fixed_a     = 8'h00;
    fixed_b     = 8'h00;
    burst_len   = 16'h0000;
    #2;
    check_zero("reset_async");
    repeat (3) @(negedge clock);
    check_zero("reset_held");
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (10) @(negedge clock);

    run_burst(1, 300, 8'h00, 8'h00, -1, -1, 1'b0);
    run_burst(0, 0, 8'h12, 8'h34, PRE + 49, 20, 1'b0);
    run_burst(3, 8, 8'h00, 8'h00, -1, -1, 1'b0);
    run_burst(3, 8, 8'h00, 8'h00, -1, -1, 1'b0);
    run_burst(2, 3, 8'h00, 8'h00, PRE + 2, -1, 1'b0);
    run_burst(4, 2, 8'h00, 8'h00, 1, -1, 1'b1);

    // Reset during RUN while word 10 is on the outputs.
    @(negedge clock);
    for (int i = 0; i < PRE + 100; i++) begin
      if (i < PRE) exp_q.push_back('{rise: 8'hA5, fall: 8'h5A, frm: 1'b0, dn: 1'b0, bsy: 1'b1, dco: 1'b1});
      else         exp_q.push_back(payload_item(1, i - PRE, 8'h00, 8'h00));
    end
    pattern_sel = 3'd1;
    burst_len   = 16'd100;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (PRE + 10) @(negedge clock);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero("reset_midrun");
    exp_q.delete();
    @(negedge clock);
    check_zero("reset_midrun_held");
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (5) @(negedge clock);
    run_burst(1, 5, 8'h00, 8'h00, -1, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      pat = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) begin
        len     = 0;
        stop_at = PRE + $urandom_range(0, 59);
      end else begin
        len     = $urandom_range(1, 60);
        stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, PRE + len - 1) : -1;
      end
      run_burst(pat, len, 8'($urandom), 8'($urandom), stop_at, -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
